twoofthree_window_sched: RTL and testbench
==========================================

# twoofthree_window_sched

Round-robin scheduler that shares one "exactly HITS of WIN" serial window checker among N requesters. Each requester owns a serial input bit `w[i]`. The scheduler grants the checker to one requester for exactly WIN consecutive cycles and counts that requester's ones. It then reports `z = (count == HITS)` with a one-cycle `done` pulse, tagged with the requester index. It sits between the per-channel serial sources and the result consumer, and sequences the shared windowed counter that the single-channel FSM implements.

## Interface
- `N`, 4: number of requesters; N ≥ 2.
- `WIN`, 3: window length in samples; WIN ≥ 1.
- `HITS`, 2: required count of ones for `z=1`; 0 ≤ HITS ≤ WIN.
- `IDW`, $clog2(N): width of `done_id`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `aresetn` in 1: one clock; reset is asynchronous and active-low.
- `req` in N: level request per requester.
- `w` in N: serial data bit per requester; only the granted bit is sampled.
- `grant` out N: one-hot, registered; all-zero when idle.
- `busy` out 1: high while a window is in progress (equals `|grant`).
- `done` out 1: one-cycle pulse when a window completes.
- `done_id` out IDW: index of the requester whose window completed; valid with `done`, holds last value otherwise.
- `z` out 1: window result; valid with `done`, holds last value otherwise.

## Operation
- States: IDLE, SAMPLE.
- Rotating pointer `ptr` (IDW bits). Priority order is ptr, ptr+1, …, N-1, 0, … ptr-1.
- Winner selection is evaluated at any edge in IDLE, and at the last-sample edge of SAMPLE. If `req != 0`, the first set bit in priority order wins.
- On a win:
  - `grant` ← onehot(winner), state ← SAMPLE.
  - `ptr` ← (winner+1) mod N.
  - cnt ← 0 and idx ← 0, where idx is the sample index (width $clog2(WIN+1)).
- On a SAMPLE edge, cnt ← cnt + `w[winner]` and idx ← idx + 1. No saturation is needed; cnt ≤ WIN.
- At the last-sample edge (idx == WIN-1):
  - `done` ← 1, `z` ← ((cnt + `w[winner]`) == HITS), `done_id` ← winner.
  - Re-arbitrate in the same edge. If a winner exists, the next SAMPLE starts immediately (zero gap); otherwise `grant` ← 0 and state ← IDLE.
- The current holder can win again back-to-back only if no other requester is pending, because rotation starts at holder+1.
- Once granted, a window always runs to completion. Deasserting `req` mid-window neither shortens nor aborts it, and its result is still reported.
- `req` changes for non-granted requesters during a window take effect only at the last-sample edge.
- Async reset mid-window aborts the window with no `done`.

## Timing
- Reset values:
  - `grant`=0, `busy`=0, `done`=0, `done_id`=0, `z`=0.
  - `ptr`=0, state IDLE, cnt=0, idx=0.
- Request latency: a `req` that is high at IDLE edge k produces `grant` high from edge k through edge k+WIN.
- `w` is sampled at edges k+1 … k+WIN.
- `done`, `z` and `done_id` are valid in the cycle after edge k+WIN; latency is WIN+1 cycles from grant.
- Throughput: one window per WIN cycles under continuous requests.
- `done` is never high for two consecutive cycles when WIN ≥ 2. When WIN = 1 it may be high every cycle.
- All outputs are registered; no combinational path from `req` or `w` to any output.

## Structure
- Package `twoofthree_pkg`: state enum {IDLE, SAMPLE}, and a function computing the rotating-priority winner plus a valid flag from (req, ptr).
- Sub-module `rr_pick`: combinational rotating-priority selector.
  - Parameter N; inputs req and ptr; outputs winner index and `any`.
  - Instantiated once.
- Top: FSM, pointer, counter and result registers.

## Test plan
- N=4/WIN=3/HITS=2: `req`=0001, `w[0]`=1,1,0 → `grant`=0001 for 3 cycles; `done`=1, `z`=1, `done_id`=0 at cycle 4; then `grant`=0000.
- Same with `w[0]`=1,1,1 → `z`=0. With `w[0]`=0,1,1 → `z`=1.
- `req`=0101 held → grants 0001 then 0100 back-to-back with no idle cycle; `done_id` 0 then 2; grants then repeat 0001, 0100.
- `req`=1111 continuous → grant order 0,1,2,3,0; `done` pulses every 3 cycles.
- `req[1]` dropped after the first sample cycle → the window completes, and `done`/`z` are reported for id 1.
- `aresetn` low at the second sample cycle → `grant`, `done` and `z` are 0 immediately; no `done` pulse. After release with `req`=0010, the first grant is id 1 (ptr=0).

Source files
------------

// File: rtl/twoofthree_pkg.sv
// Shared types and the rotating-priority winner function for the windowed scheduler.
package twoofthree_pkg;

    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ..., wrapping modulo n.
    function automatic pick_t rr_winner(
        input logic [MAX_N-1:0] req,
        input int unsigned      ptr,
        input int unsigned      n
    );
        pick_t       p;
        int unsigned j;
        p.valid = 1'b0;
        p.idx   = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                j = (ptr + i) % n;
                if (!p.valid && req[j[4:0]]) begin
                    p.valid = 1'b1;
                    p.idx   = j[4:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/twoofthree_window_sched_if.sv
// Request/data/result bundle between serial sources, the scheduler and the result consumer.
interface twoofthree_window_sched_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   w;
    logic [N-1:0]   grant;
    logic           busy;
    logic           done;
    logic [IDW-1:0] done_id;
    logic           z;

    modport master (
        output req, w,
        input  grant, busy, done, done_id, z
    );

    modport slave (
        input  req, w,
        output grant, busy, done, done_id, z
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: winner index and an any-request flag.
module rr_pick
    import twoofthree_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any
);

    logic [MAX_N-1:0] req_ext;
    pick_t            p;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        p              = rr_winner(req_ext, 32'(ptr), 32'(N));
        winner         = IDW'(p.idx);
        any            = p.valid;
    end

endmodule

// File: rtl/twoofthree_window_sched.sv
// Round-robin scheduler time-sharing one "exactly HITS of WIN" serial window counter
// among N requesters; reports each window's result with a tagged one-cycle done pulse.
module twoofthree_window_sched
    import twoofthree_pkg::*;
#(
    parameter int N    = 4,
    parameter int WIN  = 3,
    parameter int HITS = 2,
    parameter int IDW  = $clog2(N)
) (
    input  logic clk,
    input  logic aresetn,
    twoofthree_window_sched_if.slave bus
);

    localparam int CW = $clog2(WIN + 1);

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [IDW-1:0] cur_reg, cur_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [CW-1:0]  idx_reg, idx_next;
    logic [N-1:0]   grant_reg, grant_next;
    logic           done_reg, done_next;
    logic [IDW-1:0] done_id_reg, done_id_next;
    logic           z_reg, z_next;

    logic [IDW-1:0] winner;
    logic           any;
    logic           sample_bit;
    logic           last;
    logic           arb;
    logic [CW:0]    final_cnt;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            cur_reg     <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            grant_reg   <= '0;
            done_reg    <= 1'b0;
            done_id_reg <= '0;
            z_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            cur_reg     <= cur_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
            done_id_reg <= done_id_next;
            z_reg       <= z_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        cur_next     = cur_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        grant_next   = grant_reg;
        done_next    = 1'b0;
        done_id_next = done_id_reg;
        z_next       = z_reg;

        sample_bit = bus.w[cur_reg];
        last       = (state_reg == SAMPLE) && (idx_reg == CW'(WIN - 1));
        arb        = (state_reg == IDLE) || last;
        final_cnt  = {1'b0, cnt_reg} + (CW+1)'(sample_bit);

        if (state_reg == SAMPLE) begin
            cnt_next = cnt_reg + CW'(sample_bit);
            idx_next = idx_reg + CW'(1);
        end

        if (last) begin
            done_next    = 1'b1;
            z_next       = (final_cnt == (CW+1)'(HITS));
            done_id_next = cur_reg;
            state_next   = IDLE;
            grant_next   = '0;
        end

        // A new window may start on the same edge the previous one reports, giving zero gap.
        if (arb && any) begin
            state_next = SAMPLE;
            grant_next = N'(1) << winner;
            cur_next   = winner;
            ptr_next   = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
            cnt_next   = '0;
            idx_next   = '0;
        end
    end

    assign bus.grant   = grant_reg;
    assign bus.busy    = |grant_reg;
    assign bus.done    = done_reg;
    assign bus.done_id = done_id_reg;
    assign bus.z       = z_reg;

endmodule

// File: tb/tb_twoofthree_window_sched.sv
// Directed bench for twoofthree_window_sched (N=4, WIN=3, HITS=2) with hand-computed expectations.
module tb_twoofthree_window_sched;

    logic clk = 1'b0;
    logic aresetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    twoofthree_window_sched_if #(.N(4)) bus ();

    twoofthree_window_sched #(.N(4), .WIN(3), .HITS(2)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
    endtask

    // One isolated window: req applied for the start edge only, bits[0] sampled first.
    task automatic window(input logic [3:0] r, input logic [2:0] bits,
                          input logic [3:0] exp_grant, input int exp_id, input int exp_z);
        bus.req = r;
        tick();
        bus.req = 4'b0000;
        chk("win_grant_start", bus.grant, exp_grant);
        chk("win_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            bus.w = bits[i] ? exp_grant : ~exp_grant;
            tick();
            if (i < 2) begin
                chk("win_grant_hold", bus.grant, exp_grant);
                chk("win_done_low", bus.done, 0);
            end
        end
        chk("win_done", bus.done, 1);
        chk("win_id", bus.done_id, exp_id);
        chk("win_z", bus.z, exp_z);
        chk("win_grant_end", bus.grant, 0);
        $display("window id=%0d z=%0d", bus.done_id, bus.z);
        tick();
        chk("win_done_pulse", bus.done, 0);
    endtask

    initial begin
        aresetn = 1'b0;
        bus.req = 4'b0000;
        bus.w   = 4'b0000;
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_id", bus.done_id, 0);
        chk("rst_z", bus.z, 0);
        tick();
        aresetn = 1'b1;

        // Single requester, three result patterns
        window(4'b0001, 3'b011, 4'b0001, 0, 1);
        window(4'b0001, 3'b111, 4'b0001, 0, 0);
        window(4'b0001, 3'b110, 4'b0001, 0, 1);

        // Two requesters held: alternating back-to-back windows
        pulse_reset();
        bus.req = 4'b0101;
        bus.w   = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("b2b_grant", bus.grant, ((c / 3) % 2 == 0) ? 1 : 4);
            chk("b2b_done", bus.done, (c >= 3 && c % 3 == 0) ? 1 : 0);
            if (c >= 3 && c % 3 == 0) begin
                chk("b2b_id", bus.done_id, (((c / 3) - 1) % 2 == 0) ? 0 : 2);
                chk("b2b_z", bus.z, 0);
                $display("window id=%0d z=%0d", bus.done_id, bus.z);
            end
        end
        bus.req = 4'b0000;
        tick();
        chk("b2b_last_done", bus.done, 1);
        chk("b2b_last_id", bus.done_id, 2);
        chk("b2b_last_grant", bus.grant, 0);
        tick();

        // All four requesting: strict rotation 0,1,2,3,0
        pulse_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            tick();
            chk("rr_grant", bus.grant, 1 << ((c / 3) % 4));
            chk("rr_done", bus.done, (c >= 3 && c % 3 == 0) ? 1 : 0);
            if (c >= 3 && c % 3 == 0) begin
                chk("rr_id", bus.done_id, ((c / 3) - 1) % 4);
                chk("rr_z", bus.z, 1);
                $display("window id=%0d z=%0d", bus.done_id, bus.z);
            end
            bus.w = (c % 3 != 2) ? 4'b1111 : 4'b0000;
        end
        bus.req = 4'b0000;
        tick();
        chk("rr_last_done", bus.done, 1);
        chk("rr_last_id", bus.done_id, 0);
        chk("rr_last_grant", bus.grant, 0);
        tick();

        // req[1] dropped after the first sample: window still completes
        bus.req = 4'b0010;
        tick();
        chk("drop_grant0", bus.grant, 2);
        bus.w = 4'b0010;
        tick();
        bus.req = 4'b0000;
        bus.w   = 4'b0000;
        chk("drop_grant1", bus.grant, 2);
        tick();
        bus.w = 4'b0010;
        chk("drop_grant2", bus.grant, 2);
        tick();
        chk("drop_done", bus.done, 1);
        chk("drop_id", bus.done_id, 1);
        chk("drop_z", bus.z, 1);
        chk("drop_grant_end", bus.grant, 0);
        $display("window id=%0d z=%0d", bus.done_id, bus.z);
        tick();

        // Async reset in the second sample cycle aborts the window
        bus.req = 4'b0001;
        tick();
        chk("abort_grant", bus.grant, 1);
        bus.req = 4'b0000;
        bus.w   = 4'b0001;
        tick();
        aresetn = 1'b0;
        #1;
        chk("abort_grant_rst", bus.grant, 0);
        chk("abort_busy_rst", bus.busy, 0);
        chk("abort_done_rst", bus.done, 0);
        chk("abort_z_rst", bus.z, 0);
        chk("abort_id_rst", bus.done_id, 0);
        bus.req = 4'b1010;
        tick();
        chk("abort_done_hold", bus.done, 0);
        chk("abort_grant_hold", bus.grant, 0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_grant", bus.grant, 2);
        bus.req = 4'b0000;
        bus.w   = 4'b0010;
        tick();
        chk("post_rst_done_low", bus.done, 0);
        tick();
        bus.w = 4'b0000;
        tick();
        chk("post_rst_done", bus.done, 1);
        chk("post_rst_id", bus.done_id, 1);
        chk("post_rst_z", bus.z, 1);
        $display("window id=%0d z=%0d", bus.done_id, bus.z);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
